multi_push_packer: RTL and testbench

- Upstream feeder for the team's multi-push/multi-pop sync FIFO.
- Accepts a batch of up to M lanes with an arbitrary (sparse) valid mask and compacts the valid lanes to the low lanes, preserving lane order.
- Holds the compacted batch in an M-entry residue buffer and drives the FIFO's thermometer-coded push/datain, pushing only as many entries as the FIFO has room for (from full/almost_full).
- Back-pressures the producer until the residue drains.

---
 rtl/multi_push_packer_lane_compactor.sv | 30 +++
 rtl/multi_push_packer.sv | 92 +++++++++
 tb/tb_multi_push_packer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_push_packer_lane_compactor.sv
// lane_compactor: packs the valid lanes of a sparse batch into the low lanes,
// preserving lane order, and reports how many lanes were valid.
module lane_compactor #(
   parameter type T     = logic [7:0],
   parameter int  M     = 4,
   localparam int CNT_W = $clog2(M + 1)
) (
   input  logic [M-1:0]     valid,
   input  T                 data [M],
   output T                 packed_data [M],
   output logic [CNT_W-1:0] cnt
);

   // Running prefix sum of valid bits gives each valid lane its destination slot.
   always_comb begin
      logic [CNT_W-1:0] pos;
      pos = '0;
      for (int i = 0; i < M; i++) begin
         packed_data[i] = '0;
      end
      for (int i = 0; i < M; i++) begin
         if (valid[i]) begin
            packed_data[pos] = data[i];
            pos = pos + CNT_W'(1);
         end
      end
      cnt = pos;
   end

endmodule

// File: rtl/multi_push_packer.sv
// multi_push_packer: compacts sparse input batches and feeds them, oldest first,
// into a multi-push FIFO. Optional zero-latency path: MULTI_PUSH_PACKER_BYPASS_EN.
module multi_push_packer #(
   parameter type T     = logic [7:0],
   parameter int  M     = 4,
   localparam int CNT_W = $clog2(M + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [M-1:0]     in_valid,
   input  T                 in_data [M],
   output logic             in_ready,
   input  logic             clear,
   output logic [M-1:0]     push,
   output T                 datain [M],
   input  logic             fifo_full,
   input  logic [M-1:1]     fifo_almost_full,
   output logic [CNT_W-1:0] hold_cnt
);

   T                 hold [M];
   T                 packed_data [M];
   T                 src [M];
   T                 shifted [M];
   logic [CNT_W-1:0] pack_cnt;
   logic [CNT_W-1:0] src_cnt;
   logic [CNT_W-1:0] free;
   logic [CNT_W-1:0] grant;
   logic             bypass;
   logic             accept;

   lane_compactor #(.T(T), .M(M)) u_compactor (
      .valid       (in_valid),
      .data        (in_data),
      .packed_data (packed_data),
      .cnt         (pack_cnt)
   );

`ifdef MULTI_PUSH_PACKER_BYPASS_EN
   assign bypass = (hold_cnt == '0) && (|in_valid);
`else
   assign bypass = 1'b0;
`endif

   // Room in the FIFO: lowest asserted almost_full index wins, full overrides all.
   always_comb begin
      free = CNT_W'(M);
      for (int i = M - 1; i >= 1; i--) begin
         if (fifo_almost_full[i]) free = CNT_W'(i);
      end
      if (fifo_full) free = '0;
   end

   always_comb begin
      src_cnt = bypass ? pack_cnt : hold_cnt;
      for (int k = 0; k < M; k++) begin
         src[k] = bypass ? packed_data[k] : hold[k];
      end
      grant = (src_cnt < free) ? src_cnt : free;
      for (int k = 0; k < M; k++) begin
         push[k]   = (int'(grant) > k);
         datain[k] = src[k];
      end
   end

   // An empty buffer always accepts; otherwise only when the residue fully drains now.
   assign in_ready = (hold_cnt == '0) || (grant == hold_cnt);
   assign accept   = (|in_valid) && in_ready;

   always_comb begin
      for (int k = 0; k < M; k++) begin
         shifted[k] = src[k];
         if (k + int'(grant) < M) shifted[k] = src[k + int'(grant)];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         for (int k = 0; k < M; k++) hold[k] <= '0;
      end else if (clear) begin
         hold_cnt <= '0;
      end else if (accept && !bypass) begin
         hold     <= packed_data;
         hold_cnt <= pack_cnt;
      end else begin
         hold     <= shifted;
         hold_cnt <= src_cnt - grant;
      end
   end

endmodule

// File: tb/tb_multi_push_packer.sv
// Directed bench for multi_push_packer with M=4 and 8-bit lanes.
module tb_multi_push_packer;

   logic       clk;
   logic       rst_n;
   logic [3:0] in_valid;
   logic [7:0] in_data [4];
   logic       in_ready;
   logic       clear;
   logic [3:0] push;
   logic [7:0] datain [4];
   logic       fifo_full;
   logic [3:1] fifo_almost_full;
   logic [2:0] hold_cnt;

   int tests_run;
   int tests_failed;
   logic [7:0] exp_q[$];

   multi_push_packer #(.T(logic [7:0]), .M(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_ready         (in_ready),
      .clear            (clear),
      .push             (push),
      .datain           (datain),
      .fifo_full        (fifo_full),
      .fifo_almost_full (fifo_almost_full),
      .hold_cnt         (hold_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
      in_data[0] = d0; in_data[1] = d1; in_data[2] = d2; in_data[3] = d3;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = '0; clear = 1'b0; fifo_full = 1'b0;
      fifo_almost_full = '0; set_data(8'h11, 8'h22, 8'h33, 8'h44);
      #2;
      tests_run++;
      if (hold_cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_hold_cnt got %0d want 0", hold_cnt); end
      tests_run++;
      if (push !== 4'b0000) begin tests_failed++; $display("FAIL reset_push got %b want 0000", push); end
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (datain[k] !== 8'h00) begin tests_failed++; $display("FAIL reset_datain%0d got %h want 00", k, datain[k]); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_sparse();
      in_valid = 4'b1010; set_data(8'hE0, 8'hB1, 8'hE2, 8'hD3);
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1 || push !== 4'b0000) begin
         tests_failed++; $display("FAIL sparse_pre got ready=%b push=%b want 1 0000", in_ready, push);
      end
      step();
      in_valid = '0;
      @(negedge clk);
      tests_run++;
      if (hold_cnt !== 3'd2) begin tests_failed++; $display("FAIL sparse_cnt got %0d want 2", hold_cnt); end
      tests_run++;
      if (push !== 4'b0011) begin tests_failed++; $display("FAIL sparse_push got %b want 0011", push); end
      tests_run++;
      if (datain[0] !== 8'hB1 || datain[1] !== 8'hD3) begin
         tests_failed++; $display("FAIL sparse_data got %h %h want b1 d3", datain[0], datain[1]);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (hold_cnt !== 3'd0 || push !== 4'b0000) begin
         tests_failed++; $display("FAIL sparse_drain got cnt=%0d push=%b want 0 0000", hold_cnt, push);
      end
      step();
   endtask

   task automatic test_partial();
      fifo_almost_full = 3'b001;
      in_valid = 4'b1111; set_data(8'hA0, 8'hB0, 8'hC0, 8'hD0);
      step();
      in_valid = '0;
      @(negedge clk);
      tests_run++;
      if (hold_cnt !== 3'd4 || push !== 4'b0001 || datain[0] !== 8'hA0) begin
         tests_failed++; $display("FAIL partial_first got cnt=%0d push=%b d0=%h want 4 0001 a0", hold_cnt, push, datain[0]);
      end
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL partial_ready got %b want 0", in_ready); end
      step();
      fifo_almost_full = '0;
      @(negedge clk);
      tests_run++;
      if (hold_cnt !== 3'd3 || push !== 4'b0111 || in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL partial_rest got cnt=%0d push=%b ready=%b want 3 0111 1", hold_cnt, push, in_ready);
      end
      tests_run++;
      if (datain[0] !== 8'hB0 || datain[1] !== 8'hC0 || datain[2] !== 8'hD0) begin
         tests_failed++; $display("FAIL partial_data got %h %h %h want b0 c0 d0", datain[0], datain[1], datain[2]);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (hold_cnt !== 3'd0) begin tests_failed++; $display("FAIL partial_drain got %0d want 0", hold_cnt); end
      step();
   endtask

   task automatic test_full();
      fifo_full = 1'b1;
      in_valid = 4'b1101; set_data(8'h51, 8'hEE, 8'h52, 8'h53);
      step();
      in_valid = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests_run++;
         if (push !== 4'b0000 || in_ready !== 1'b0 || hold_cnt !== 3'd3) begin
            tests_failed++; $display("FAIL full_hold c%0d got push=%b ready=%b cnt=%0d want 0000 0 3", c, push, in_ready, hold_cnt);
         end
         step();
      end
      fifo_full = 1'b0; fifo_almost_full = 3'b100;
      @(negedge clk);
      tests_run++;
      if (push !== 4'b0111 || datain[0] !== 8'h51 || datain[1] !== 8'h52 || datain[2] !== 8'h53) begin
         tests_failed++; $display("FAIL full_release got push=%b %h %h %h want 0111 51 52 53", push, datain[0], datain[1], datain[2]);
      end
      step();
      fifo_almost_full = '0;
   endtask

   task automatic test_back_to_back();
      for (int b = 0; b <= 8; b++) begin
         if (b < 8) begin
            in_valid = 4'b1111;
            for (int k = 0; k < 4; k++) begin
               in_data[k] = 8'(b * 4 + k + 8'h40);
            end
         end else begin
            in_valid = '0;
         end
         @(negedge clk);
         tests_run++;
         if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready batch%0d got %b want 1", b, in_ready); end
         if (b > 0) begin
            tests_run++;
            if (push !== 4'b1111) begin tests_failed++; $display("FAIL b2b_push batch%0d got %b want 1111", b, push); end
            for (int k = 0; k < 4; k++) begin
               logic [7:0] e;
               e = exp_q.pop_front();
               tests_run++;
               if (datain[k] !== e) begin tests_failed++; $display("FAIL b2b_data lane%0d got %h want %h", k, datain[k], e); end
            end
         end
         if (b < 8) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(8'(b * 4 + k + 8'h40));
         end
         step();
      end
      @(negedge clk);
      tests_run++;
      if (hold_cnt !== 3'd0 || push !== 4'b0000) begin
         tests_failed++; $display("FAIL b2b_idle got cnt=%0d push=%b want 0 0000", hold_cnt, push);
      end
      step();
   endtask

   task automatic test_clear();
      fifo_full = 1'b1;
      in_valid = 4'b0111; set_data(8'h61, 8'h62, 8'h63, 8'hEE);
      step();
      in_valid = 4'b0011; set_data(8'h71, 8'h72, 8'hEE, 8'hEE);
      clear = 1'b1;
      @(negedge clk);
      tests_run++;
      if (hold_cnt !== 3'd3) begin tests_failed++; $display("FAIL clear_pre got %0d want 3", hold_cnt); end
      step();
      clear = 1'b0; in_valid = '0; fifo_full = 1'b0;
      @(negedge clk);
      tests_run++;
      if (hold_cnt !== 3'd0 || push !== 4'b0000) begin
         tests_failed++; $display("FAIL clear_drop got cnt=%0d push=%b want 0 0000", hold_cnt, push);
      end
      step();
   endtask

   task automatic test_async_reset();
      fifo_full = 1'b1;
      in_valid = 4'b0011; set_data(8'h81, 8'h82, 8'hEE, 8'hEE);
      step();
      in_valid = '0; fifo_full = 1'b0; fifo_almost_full = 3'b010;
      @(negedge clk);
      tests_run++;
      if (hold_cnt !== 3'd2 || push !== 4'b0011) begin
         tests_failed++; $display("FAIL arst_pre got cnt=%0d push=%b want 2 0011", hold_cnt, push);
      end
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (hold_cnt !== 3'd0 || push !== 4'b0000 || in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL arst_now got cnt=%0d push=%b ready=%b want 0 0000 1", hold_cnt, push, in_ready);
      end
      #1 rst_n = 1'b1;
      fifo_almost_full = '0;
      step();
   endtask

   task automatic test_bypass();
      in_valid = 4'b0001; set_data(8'h91, 8'hEE, 8'hEE, 8'hEE);
      #1;
      tests_run++;
      if (push !== 4'b0001 || datain[0] !== 8'h91 || in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL bypass_now got push=%b d0=%h ready=%b want 0001 91 1", push, datain[0], in_ready);
      end
      step();
      in_valid = '0;
      @(negedge clk);
      tests_run++;
      if (hold_cnt !== 3'd0 || push !== 4'b0000) begin
         tests_failed++; $display("FAIL bypass_after got cnt=%0d push=%b want 0 0000", hold_cnt, push);
      end
      step();
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
`ifdef MULTI_PUSH_PACKER_BYPASS_EN
      test_bypass();
`else
      test_sparse();
      test_partial();
      test_full();
      test_back_to_back();
      test_clear();
      test_async_reset();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
